// File: rtl/decode_div_61s_22ns_40_seq.sv
// ---------------------------------------------------------------------------
// decode_div_61s_22ns_40_seq
//
// Sequential divider for the decoder datapath. It reverses the encoder's
// fixed-point scaling multiply by dividing a signed DIN0_WIDTH-bit value by an
// unsigned DIN1_WIDTH-bit scale. The result is a signed DOUT_WIDTH-bit
// quotient that saturates on range overflow or on divide-by-zero.
//
// Algorithm: radix-2 restoring division on the dividend magnitude, one quotient
// bit per enabled clock. The sign is applied and saturation is resolved in a
// final FIX cycle. ce gates every register so the block follows HLS pipeline
// stalls.
//
// Configuration macro: DECODE_DIV_ROUND_EN
//   defined   : magnitude is pre-biased by din1>>1, giving round-half-away-
//               from-zero.
//   undefined : quotient truncates toward zero (C semantics). This is the
//               default build.
//   Latency is the same in both builds.
//
// Ports:
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   ce       in   clock enable; low freezes all state and outputs
//   start    in   request, sampled only in IDLE with ce=1
//   din0     in   signed dividend   [DIN0_WIDTH-1:0]
//   din1     in   unsigned divisor  [DIN1_WIDTH-1:0]
//   busy     out  high from the accepting edge until done is asserted
//   done     out  one-cycle pulse; dout/ovf/dbz are valid
//   dout     out  signed quotient  [DOUT_WIDTH-1:0], held until the next done
//   ovf      out  quotient was saturated (range)
//   dbz      out  divisor was zero
//
// Latency: done is high after edge E0+M+1, where M = DIN0_WIDTH+1 and E0 is
// the accepting edge. With a zero divisor, done is high after edge E0+1.
// ---------------------------------------------------------------------------
module decode_div_61s_22ns_40_seq #(
  parameter int ID         = 1,
  parameter int DIN0_WIDTH = 61,
  parameter int DIN1_WIDTH = 22,
  parameter int DOUT_WIDTH = 40
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  ovf,
  output logic                  dbz
);

  // Magnitude path is one bit wider than the dividend so |-2^(W-1)| fits.
  localparam int M  = DIN0_WIDTH + 1;
  // Partial remainder needs one guard bit above the divisor.
  localparam int R  = DIN1_WIDTH + 1;
  localparam int CW = $clog2(M);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_LAST = CW'(M - 1);
  localparam logic [M-1:0]          MAG_ZERO = {M{1'b0}};
  localparam logic [M-1:0]          MAG_ONE  = {{(M-1){1'b0}}, 1'b1};
  localparam logic [R-1:0]          REM_ZERO = {R{1'b0}};
  localparam logic [DIN1_WIDTH-1:0] DIV_ZERO = {DIN1_WIDTH{1'b0}};
  localparam logic [DOUT_WIDTH-1:0] OUT_ZERO = {DOUT_WIDTH{1'b0}};
  localparam logic [DOUT_WIDTH-1:0] OUT_ONE  = {{(DOUT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DOUT_WIDTH-1:0] OUT_MAX  = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [DOUT_WIDTH-1:0] OUT_MIN  = {1'b1, {(DOUT_WIDTH-1){1'b0}}};

  // Saturation limits on the full M-bit quotient magnitude.
  // Positive results may reach 2^(DOUT_WIDTH-1)-1; negative results may reach
  // a magnitude of 2^(DOUT_WIDTH-1).
  localparam logic [M-1:0] LIM_POS = {{(M-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic [M-1:0] LIM_NEG = {{(M-DOUT_WIDTH){1'b0}}, 1'b1, {(DOUT_WIDTH-1){1'b0}}};

  // ID only tags the instance; it deliberately selects nothing.
  if (ID < 0) begin : g_id_tag
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // |x| of the signed dividend, widened by one bit.
  function automatic logic [M-1:0] abs_mag(input logic [DIN0_WIDTH-1:0] x);
    logic [M-1:0] ext;
    ext = {x[DIN0_WIDTH-1], x};
    if (x[DIN0_WIDTH-1]) begin
      abs_mag = ~ext + MAG_ONE;
    end else begin
      abs_mag = ext;
    end
  endfunction

  // Apply the sign and saturate. Returns {dout, ovf, dbz}.
  function automatic logic [DOUT_WIDTH+1:0] fix_result(input logic         neg,
                                                        input logic         zero,
                                                        input logic [M-1:0] q);
    logic [DOUT_WIDTH-1:0] val;
    logic                  o;
    logic                  z;
    if (zero) begin
      // Divide-by-zero saturates toward the dividend's sign; zero counts as positive.
      z = 1'b1;
      o = 1'b0;
      if (neg) begin
        val = OUT_MIN;
      end else begin
        val = OUT_MAX;
      end
    end else if (neg) begin
      z = 1'b0;
      if (q > LIM_NEG) begin
        o   = 1'b1;
        val = OUT_MIN;
      end else begin
        o   = 1'b0;
        val = ~q[DOUT_WIDTH-1:0] + OUT_ONE;
      end
    end else begin
      z = 1'b0;
      if (q > LIM_POS) begin
        o   = 1'b1;
        val = OUT_MAX;
      end else begin
        o   = 1'b0;
        val = q[DOUT_WIDTH-1:0];
      end
    end
    fix_result = {val, o, z};
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic                  neg_q,   neg_d;
  logic                  zero_q,  zero_d;
  // mag_q starts as the dividend magnitude. Quotient bits shift in at the LSB
  // while dividend bits leave at the MSB.
  logic [M-1:0]          mag_q,   mag_d;
  logic [R-1:0]          rem_q,   rem_d;
  logic [DIN1_WIDTH-1:0] div_q,   div_d;
  logic                  busy_q,  busy_d;
  logic                  done_q,  done_d;
  logic [DOUT_WIDTH-1:0] dout_q,  dout_d;
  logic                  ovf_q,   ovf_d;
  logic                  dbz_q,   dbz_d;

  logic [R-1:0]            rem_shift_s;
  logic [R-1:0]            rem_sub_s;
  logic                    q_bit_s;
  logic [DOUT_WIDTH+1:0]   fix_s;

  // One restoring step: shift the next dividend bit into the remainder, then
  // subtract the divisor when it fits.
  always_comb begin
    rem_shift_s = {rem_q[R-2:0], mag_q[M-1]};
    rem_sub_s   = rem_shift_s - {1'b0, div_q};
    q_bit_s     = (rem_shift_s >= {1'b0, div_q});
    fix_s       = fix_result(neg_q, zero_q, mag_q);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    rem_d   = rem_q;
    div_d   = div_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          neg_d  = din0[DIN0_WIDTH-1];
          div_d  = din1;
          rem_d  = REM_ZERO;
          cnt_d  = CNT_ZERO;
          busy_d = 1'b1;
`ifdef DECODE_DIV_ROUND_EN
          // Bias by half the divisor so truncation rounds half away from zero.
          mag_d  = abs_mag(din0) + {{(M-DIN1_WIDTH+1){1'b0}}, din1[DIN1_WIDTH-1:1]};
`else
          mag_d  = abs_mag(din0);
`endif
          if (din1 == DIV_ZERO) begin
            zero_d  = 1'b1;
            state_d = ST_FIX;
          end else begin
            zero_d  = 1'b0;
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        mag_d = {mag_q[M-2:0], q_bit_s};
        if (q_bit_s) begin
          rem_d = rem_sub_s;
        end else begin
          rem_d = rem_shift_s;
        end
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_CALC;
        end
      end

      ST_FIX: begin
        dout_d  = fix_s[DOUT_WIDTH+1:2];
        ovf_d   = fix_s[1];
        dbz_d   = fix_s[0];
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath flops: ce low holds everything, reset_n clears everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      mag_q   <= MAG_ZERO;
      rem_q   <= REM_ZERO;
      div_q   <= DIV_ZERO;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= OUT_ZERO;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_decode_div_61s_22ns_40_seq.sv
`timescale 1ns/1ps
module tb_decode_div_61s_22ns_40_seq;

  localparam int W0  = 61;
  localparam int W1  = 22;
  localparam int WO  = 40;
  localparam int LAT = 63;
  localparam logic [WO-1:0] MAXP = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MINN = {1'b1, {(WO-1){1'b0}}};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce = 1'b0;
  logic          start = 1'b0;
  logic [W0-1:0] din0 = '0;
  logic [W1-1:0] din1 = '0;
  logic          busy, done, ovf, dbz;
  logic [WO-1:0] dout;

  decode_div_61s_22ns_40_seq #(
    .ID(1), .DIN0_WIDTH(W0), .DIN1_WIDTH(W1), .DOUT_WIDTH(WO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .start(start),
    .din0(din0), .din1(din1),
    .busy(busy), .done(done), .dout(dout), .ovf(ovf), .dbz(dbz)
  );

  typedef struct {
    logic [WO-1:0] dout;
    bit            ovf;
    bit            dbz;
    int            acc;
    int            lat;
  } exp_t;

  exp_t          sb_q[$];
  int            vectors = 0;
  int            miscompares = 0;
  int            ce_edges = 0;
  int            clk_edges = 0;
  int            n_done = 0;
  int            last_done_ce = -1;
  int            last_done_clk = 0;
  logic [WO-1:0] last_exp = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    clk_edges <= clk_edges + 1;
    if (ce) ce_edges <= ce_edges + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: plain integer division on the signed dividend.
  function automatic exp_t model(input logic [W0-1:0] a, input logic [W1-1:0] b);
    exp_t              e;
    longint            sa;
    longint            neg_q;
    longint unsigned   mag, q, bu;
    bit                neg;
    sa  = longint'($signed(a));
    neg = (sa < 0);
    mag = neg ? longint'(-sa) : sa;
    bu  = longint'(b);
    e.ovf = 1'b0;
    e.dbz = 1'b0;
    e.acc = 0;
    e.lat = LAT;
    if (bu == 0) begin
      e.dbz  = 1'b1;
      e.lat  = 1;
      e.dout = neg ? MINN : MAXP;
    end else begin
`ifdef DECODE_DIV_ROUND_EN
      mag = mag + bu / 2;
`endif
      q = mag / bu;
      if (!neg) begin
        if (q > (64'd1 << 39) - 64'd1) begin
          e.ovf = 1'b1; e.dout = MAXP;
        end else begin
          e.dout = q[WO-1:0];
        end
      end else begin
        if (q > (64'd1 << 39)) begin
          e.ovf = 1'b1; e.dout = MINN;
        end else begin
          neg_q  = -longint'(q);
          e.dout = neg_q[WO-1:0];
        end
      end
    end
    return e;
  endfunction

  // Monitor: one pop per done pulse (done may be held high by ce stalls).
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && done && ce_edges != last_done_ce) begin
      last_done_ce  = ce_edges;
      last_done_clk = clk_edges;
      n_done++;
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done with empty scoreboard, dout=%0h", dout);
      end else begin
        e = sb_q.pop_front();
        check("dout", 64'(dout), 64'(e.dout));
        check("ovf", 64'(ovf), 64'(e.ovf));
        check("dbz", 64'(dbz), 64'(e.dbz));
        check("latency_ce_edges", 64'(ce_edges - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [W0-1:0] a, input logic [W1-1:0] b,
                       input int stall_at, input int stall_len, input bit poke,
                       output int raw_lat);
    exp_t e;
    int   base;
    int   acc_clk;
    int   t;
    base  = n_done;
    din0  = a;
    din1  = b;
    start = 1'b1;
    ce    = 1'b1;
    step();
    start   = 1'b0;
    e       = model(a, b);
    e.acc   = ce_edges;
    acc_clk = clk_edges;
    sb_q.push_back(e);
    last_exp = e.dout;
    check("busy_after_accept", 64'(busy), 64'd1);
    t = 0;
    while (n_done == base && t < 400) begin
      ce = !(t >= stall_at && t < stall_at + stall_len);
      if (poke && (t % 7) == 3) begin
        start = 1'b1;
        din0  = W0'({$urandom(), $urandom()});
        din1  = W1'($urandom());
      end else begin
        start = 1'b0;
      end
      step();
      t++;
      if (n_done == base) check("busy_while_calc", 64'(busy), 64'd1);
    end
    start = 1'b0;
    ce    = 1'b1;
    if (n_done == base) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", t);
      sb_q.delete();
      raw_lat = -1;
    end else begin
      raw_lat = last_done_clk - acc_clk;
      check("busy_at_done", 64'(busy), 64'd0);
      step();
      check("done_pulse_width", 64'(done), 64'd0);
    end
  endtask

  initial begin
    int            raw;
    logic [63:0]   r;
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    int            sh;

    repeat (3) step();
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_dbz", 64'(dbz), 64'd0);
    reset_n = 1'b1;
    ce      = 1'b1;
    step();

    // Directed cases.
    issue(61'd1000000, 22'd1000, 0, 0, 1'b0, raw);
    check("t1_raw_latency", 64'(raw), 64'd63);
    issue(-61'sd7, 22'd2, 0, 0, 1'b0, raw);
    issue(61'd7, 22'd3, 0, 0, 1'b0, raw);
    issue(61'd5, 22'd0, 0, 0, 1'b0, raw);
    check("dbz_raw_latency", 64'(raw), 64'd1);
    issue(-61'sd5, 22'd0, 0, 0, 1'b0, raw);
    issue(61'd0, 22'd0, 0, 0, 1'b0, raw);
    issue(61'h0800_0000_0000_0000, 22'd1, 0, 0, 1'b0, raw);
    issue(61'h1000_0000_0000_0000, 22'd1, 0, 0, 1'b0, raw);
    issue(61'h1FFF_FF80_0000_0000, 22'd1, 0, 0, 1'b0, raw);
    issue(61'h0000_007F_FFFF_FFFF, 22'd1, 0, 0, 1'b0, raw);
    issue(61'h0000_0080_0000_0000, 22'd1, 0, 0, 1'b0, raw);
    issue(61'h0FFF_FFFF_FFFF_FFFF, 22'h3FFFFF, 0, 0, 1'b0, raw);

    // Stall 10 cycles mid-calculation while poking start.
    issue(61'd1000000, 22'd1000, 20, 10, 1'b1, raw);
    check("stall_raw_latency", 64'(raw), 64'd73);

    // Asynchronous reset partway through a calculation.
    din0  = 61'd123456789;
    din1  = 22'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    check("pre_reset_busy", 64'(busy), 64'd1);
    repeat (20) step();
    reset_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_dout", 64'(dout), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_dbz", 64'(dbz), 64'd0);
    step();
    reset_n = 1'b1;
    step();
    issue(61'd12, 22'd4, 0, 0, 1'b0, raw);

    // Randomized operands with random stalls and ignored start pokes.
    for (int i = 0; i < 24; i++) begin
      r  = {$urandom(), $urandom()};
      sh = $urandom_range(0, 63);
      r  = r >> sh;
      a  = r[W0-1:0];
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W1'($urandom_range(1, 16));
        default: b = W1'($urandom());
      endcase
      issue(a, b, $urandom_range(0, 60), $urandom_range(0, 8), 1'($urandom_range(0, 1)), raw);
    end

    // Result holds while idle.
    repeat (5) step();
    check("dout_hold", 64'(dout), 64'(last_exp));
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
